eq_sample_scheduler: RTL and testbench

EQ_SAMPLE_SCHEDULER -- requirements
Module: eq_sample_scheduler

---
 rtl/eq_pkg.sv | 26 ++
 rtl/eq_sample_tick.sv | 32 +++
 rtl/eq_sample_scheduler.sv | 148 ++++++++++++++
 tb/tb_eq_sample_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer sample scheduler: FSM encoding,
// default parameter values and signed saturation limits.
package eq_pkg;

    localparam int TICK_MAX_DEF = 2267;  // 100 MHz / 2268 ~= 44.09 kHz
    localparam int NBANDS_DEF   = 3;
    localparam int DW_DEF       = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADC       = 3'd1,
        S_BAND_GO   = 3'd2,
        S_BAND_WAIT = 3'd3,
        S_DAC       = 3'd4
    } state_t;

    // Largest / smallest value representable in a dw-bit signed sample.
    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/eq_sample_tick.sv
// Sample-rate tick generator: counts 0..TICK_MAX while enabled and flags
// the terminal count; held at zero while disabled.
module eq_sample_tick
    import eq_pkg::*;
#(
    parameter int TICK_MAX = TICK_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_MAX);

    logic [CW-1:0] cnt;

    // Free-running period counter, parked at zero whenever en is low.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/eq_sample_scheduler.sv
// Per-sample sequencer: fetch one ADC sample, run it through each band of a
// shared filter, sum the band outputs, saturate, and hand the result to the DAC.
module eq_sample_scheduler
    import eq_pkg::*;
#(
    parameter int TICK_MAX = TICK_MAX_DEF,
    parameter int NBANDS   = NBANDS_DEF,
    parameter int DW       = DW_DEF,
    localparam int SW      = (NBANDS > 1) ? $clog2(NBANDS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    output logic                 adc_req,
    input  logic                 adc_ack,
    input  logic signed [DW-1:0] adc_data,
    output logic                 band_start,
    output logic [SW-1:0]        band_sel,
    output logic [DW-1:0]        band_in,
    input  logic                 band_done,
    input  logic signed [DW-1:0] band_out,
    output logic                 dac_valid,
    output logic [DW-1:0]        dac_data,
    input  logic                 dac_ready,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    // One guard bit beyond the growth of NBANDS additions.
    localparam int AW = DW + $clog2(NBANDS) + 1;
    localparam logic [SW-1:0]        LAST_BAND = SW'(NBANDS - 1);
    localparam logic signed [AW-1:0] ACC_HI    = AW'(sat_max(DW));
    localparam logic signed [AW-1:0] ACC_LO    = AW'(sat_min(DW));
    localparam logic [DW-1:0]        OUT_HI    = DW'(sat_max(DW));
    localparam logic [DW-1:0]        OUT_LO    = DW'(sat_min(DW));

    logic tick;

    eq_sample_tick #(.TICK_MAX(TICK_MAX)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    state_t                state, state_n;
    logic signed [AW-1:0]  acc, acc_n, acc_sum;
    logic                  adc_req_n, band_start_n, dac_valid_n, busy_n, overrun_n;
    logic [SW-1:0]         band_sel_n;
    logic [DW-1:0]         band_in_n, dac_data_n;

    assign acc_sum = acc + {{(AW - DW){band_out[DW-1]}}, band_out};

    // State and every output are registered from the next-value logic below.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            adc_req    <= 1'b0;
            band_start <= 1'b0;
            band_sel   <= '0;
            band_in    <= '0;
            acc        <= '0;
            dac_valid  <= 1'b0;
            dac_data   <= '0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            adc_req    <= adc_req_n;
            band_start <= band_start_n;
            band_sel   <= band_sel_n;
            band_in    <= band_in_n;
            acc        <= acc_n;
            dac_valid  <= dac_valid_n;
            dac_data   <= dac_data_n;
            busy       <= busy_n;
            overrun    <= overrun_n;
        end
    end

    // Next state and next output values; pulses default low, data holds.
    always_comb begin
        state_n      = state;
        adc_req_n    = 1'b0;
        band_start_n = 1'b0;
        band_sel_n   = band_sel;
        band_in_n    = band_in;
        acc_n        = acc;
        dac_valid_n  = 1'b0;
        dac_data_n   = dac_data;
        overrun_n    = overrun_clr ? 1'b0 : overrun;

        // A tick while a frame is still running is dropped and flagged;
        // setting wins over a simultaneous clear.
        if (tick && state != S_IDLE) overrun_n = 1'b1;

        case (state)
            S_IDLE: begin
                if (tick) begin
                    state_n   = S_ADC;
                    adc_req_n = 1'b1;
                end
            end
            S_ADC: begin
                if (adc_ack) begin
                    band_in_n    = adc_data;
                    state_n      = S_BAND_GO;
                    band_start_n = 1'b1;
                end else begin
                    adc_req_n = 1'b1;
                end
            end
            S_BAND_GO: begin
                state_n = S_BAND_WAIT;
            end
            S_BAND_WAIT: begin
                if (band_done) begin
                    acc_n = acc_sum;
                    if (band_sel != LAST_BAND) begin
                        band_sel_n   = band_sel + SW'(1);
                        state_n      = S_BAND_GO;
                        band_start_n = 1'b1;
                    end else begin
                        state_n     = S_DAC;
                        dac_valid_n = 1'b1;
                        if (acc_sum > ACC_HI)      dac_data_n = OUT_HI;
                        else if (acc_sum < ACC_LO) dac_data_n = OUT_LO;
                        else                       dac_data_n = acc_sum[DW-1:0];
                    end
                end
            end
            S_DAC: begin
                if (dac_ready) begin
                    state_n    = S_IDLE;
                    acc_n      = '0;
                    band_sel_n = '0;
                end else begin
                    dac_valid_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_eq_sample_scheduler.sv
// Scoreboard bench for eq_sample_scheduler: behavioural ADC, filter and DAC
// partners; expected DAC words are queued up front and popped on handshake.
module tb_eq_sample_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        adc_req;
    logic        adc_ack = 1'b0;
    logic [15:0] adc_val = '0;
    logic        band_start;
    logic [1:0]  band_sel;
    logic [15:0] band_in;
    logic        band_done = 1'b0;
    logic [15:0] band_out = '0;
    logic        dac_valid;
    logic [15:0] dac_data;
    logic        dac_ready = 1'b1;
    logic        busy;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    always #5 clk = ~clk;

    eq_sample_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .adc_req     (adc_req),
        .adc_ack     (adc_ack),
        .adc_data    (adc_val),
        .band_start  (band_start),
        .band_sel    (band_sel),
        .band_in     (band_in),
        .band_done   (band_done),
        .band_out    (band_out),
        .dac_valid   (dac_valid),
        .dac_data    (dac_data),
        .dac_ready   (dac_ready),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] bvals [3];
    int band_lat = 5;
    int ncyc = 0;
    int rises = 0;
    int rise_t = 0;
    int starts = 0;
    logic req_q = 1'b0;
    int cd = 0;
    int cur = 0;
    int exp_sel = 0;
    logic [15:0] held = '0;
    logic held_v = 1'b0;
    int stab_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 dac_ready = v;
    endtask

    task automatic wait_rise(input string nm, input int bound);
        int r0;
        int n;
        r0 = rises;
        n = 0;
        while (rises == r0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_seen"}, 64'(rises != r0), 64'd1);
    endtask

    always @(posedge clk) ncyc <= ncyc + 1;

    // ADC partner: acknowledges the first cycle a request is visible.
    initial forever begin
        @(negedge clk);
        adc_ack = adc_req && reset;
    end

    // adc_req rising-edge counter with timestamp.
    initial forever begin
        @(negedge clk);
        if (adc_req && !req_q) begin
            rises++;
            rise_t = ncyc;
        end
        req_q = adc_req;
    end

    // Filter partner: answers each start band_lat cycles later.
    initial forever begin
        @(negedge clk);
        band_done = 1'b0;
        if (!reset) begin
            cd = 0;
            exp_sel = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    band_done = 1'b1;
                    band_out = bvals[cur];
                end
            end
            if (band_start) begin
                starts++;
                chk("band_sel", 64'(band_sel), 64'(exp_sel));
                chk("band_in", 64'(band_in), 64'(adc_val));
                cur = int'(band_sel) % 3;
                exp_sel = (exp_sel + 1) % 3;
                cd = band_lat;
            end
        end
    end

    // DAC monitor: pops the scoreboard on each handshake, tracks stability.
    initial forever begin
        @(negedge clk);
        if (reset && dac_valid) begin
            if (dac_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dac_unexpected actual=%0h expected=none", dac_data);
                end else begin
                    chk("dac_data", 64'(dac_data), 64'(exp_q.pop_front()));
                end
                held_v = 1'b0;
            end else begin
                if (held_v && dac_data !== held) stab_err++;
                held = dac_data;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        int c0, t_prev, r0, s0, n;
        bvals = '{16'd10, 16'd20, 16'd30};
        adc_val = 16'd100;

        // reset state
        cyc(3);
        chk("reset_outs", 64'({adc_req, band_start, band_sel, band_in, dac_valid,
                               dac_data, busy, overrun}), 64'd0);

        // basic frames and tick period
        exp_q.push_back(16'd60);
        exp_q.push_back(16'd60);
        @(negedge clk);
        reset = 1'b1;
        en = 1'b1;
        c0 = ncyc;
        wait_rise("frame1", 2500);
        chk("tick_first", 64'(rise_t - c0), 64'd2268);
        t_prev = rise_t;
        wait_rise("frame2", 2500);
        chk("tick_period", 64'(rise_t - t_prev), 64'd2268);
        cyc(100);
        chk("q_empty_a", 64'(exp_q.size()), 64'd0);
        chk("ovr_a", 64'(overrun), 64'd0);
        chk("idle_a", 64'(busy), 64'd0);

        // positive and negative saturation
        bvals = '{16'h7000, 16'h7000, 16'h7000};
        exp_q.push_back(16'h7FFF);
        wait_rise("frame_sat_hi", 2500);
        cyc(100);
        chk("q_empty_hi", 64'(exp_q.size()), 64'd0);
        bvals = '{16'h9000, 16'h9000, 16'h9000};
        exp_q.push_back(16'h8000);
        wait_rise("frame_sat_lo", 2500);
        cyc(100);
        chk("q_empty_lo", 64'(exp_q.size()), 64'd0);

        // DAC back-pressure across a tick
        adc_val = 16'd5;
        bvals = '{16'd1, 16'd2, 16'd3};
        exp_q.push_back(16'd6);
        set_ready(1'b0);
        wait_rise("frame_hold", 2500);
        cyc(100);
        r0 = rises;
        s0 = starts;
        cyc(2900);
        chk("hold_valid", 64'(dac_valid), 64'd1);
        chk("hold_data", 64'(dac_data), 64'd6);
        chk("hold_stable", 64'(stab_err), 64'd0);
        chk("hold_ovr", 64'(overrun), 64'd1);
        chk("hold_rises", 64'(rises - r0), 64'd0);
        chk("hold_starts", 64'(starts - s0), 64'd0);
        set_ready(1'b1);
        cyc(3);
        chk("q_empty_c", 64'(exp_q.size()), 64'd0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        chk("idle_c", 64'(busy), 64'd0);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        chk("ovr_clr", 64'(overrun), 64'd0);

        // reset in the middle of BAND_WAIT
        adc_val = 16'd7;
        bvals = '{16'd1, 16'd1, 16'd1};
        band_lat = 20;
        wait_rise("frame_rst", 2500);
        s0 = starts;
        n = 0;
        while (starts == s0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_start_seen", 64'(starts != s0), 64'd1);
        cyc(5);
        chk("rst_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        cyc(1);
        chk("rst_outs", 64'({adc_req, band_start, band_sel, band_in, dac_valid,
                             dac_data, busy, overrun}), 64'd0);
        cyc(2);
        reset = 1'b1;
        exp_q.delete();
        r0 = rises;
        s0 = starts;
        cyc(2200);
        chk("rst_no_start", 64'(starts - s0), 64'd0);
        chk("rst_no_req", 64'(rises - r0), 64'd0);

        // en dropped mid-frame: frame finishes, then silence
        band_lat = 5;
        adc_val = 16'd100;
        bvals = '{16'd10, 16'd20, 16'd30};
        exp_q.push_back(16'd60);
        wait_rise("frame_en", 600);
        en = 1'b0;
        cyc(100);
        chk("q_empty_e", 64'(exp_q.size()), 64'd0);
        r0 = rises;
        cyc(3000);
        chk("en_off_rises", 64'(rises - r0), 64'd0);
        chk("en_off_busy", 64'(busy), 64'd0);
        chk("en_off_req", 64'(adc_req), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
